// File: rtl/piano_pkg.sv
// Shared piano constants: key indexing, voice state record and note half-period table.
package piano_pkg;

  localparam int NUM_KEYS      = 8;
  localparam int KEY_W         = $clog2(NUM_KEYS);
  localparam int AGE_W         = 4;
  localparam int HALF_PERIOD_W = 17;

  typedef logic [KEY_W-1:0]         key_idx_t;
  typedef logic [AGE_W-1:0]         age_t;
  typedef logic [HALF_PERIOD_W-1:0] half_period_t;

  typedef struct packed {
    logic     en;
    key_idx_t key;
    age_t     age;
  } voice_t;

  // Half periods in clk cycles for C4..C5 at a 50 MHz clock.
  function automatic half_period_t half_period(input key_idx_t k);
    half_period_t hp;
    case (k)
      3'd0:    hp = 17'd95555;
      3'd1:    hp = 17'd85132;
      3'd2:    hp = 17'd75843;
      3'd3:    hp = 17'd71586;
      3'd4:    hp = 17'd63776;
      3'd5:    hp = 17'd56818;
      3'd6:    hp = 17'd50620;
      3'd7:    hp = 17'd47778;
      default: hp = 17'd95555;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/lowest_set_pick.sv
// First-one finder: reports whether any bit of vec is set and the index of the lowest one.
module lowest_set_pick #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Shares NUM_VOICES tone-generator voices among NUM_KEYS held keys, one grant per cycle.
// Define VOICE_STEAL_EN to let a waiting key take over the oldest voice when none is free.
module voice_allocator #(
  parameter int NUM_KEYS   = piano_pkg::NUM_KEYS,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = piano_pkg::KEY_W,
  parameter int AGE_W      = piano_pkg::AGE_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_KEYS-1:0]               key_req,
  output logic [NUM_VOICES-1:0]             voice_en,
  output logic [NUM_VOICES*KEY_W-1:0]       voice_key,
  output logic [NUM_KEYS-1:0]               key_granted,
  output logic [NUM_KEYS-1:0]               pending,
  output logic                              busy,
  output logic [$clog2(NUM_VOICES+1)-1:0]   voices_used
);
  import piano_pkg::*;

  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int CNT_W  = $clog2(NUM_VOICES + 1);

  logic [NUM_KEYS-1:0]   key_q, pending_q, granted_q;
  logic [NUM_KEYS-1:0]   pending_n, granted_n;
  voice_t                voice_q [NUM_VOICES];
  voice_t                voice_n [NUM_VOICES];

  logic [NUM_KEYS-1:0]   key_press, key_rel, req;
  logic [NUM_KEYS-1:0]   win_onehot, stolen_onehot;
  logic [NUM_VOICES-1:0] rel_voice, free_vec;
  logic                  win_found, free_found, do_steal, grant;
  logic [KEY_W-1:0]      win_idx;
  logic [VIDX_W-1:0]     free_idx, steal_idx, target;

  assign key_press = key_req & ~key_q;
  assign key_rel   = ~key_req & key_q;
  assign req       = (pending_q | key_press) & key_req & ~granted_q;

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      rel_voice[v] = voice_q[v].en & key_rel[voice_q[v].key];
      free_vec[v]  = ~voice_q[v].en;
    end
  end

  lowest_set_pick #(.W(NUM_KEYS), .IDX_W(KEY_W)) u_winner (
    .vec   (req),
    .found (win_found),
    .index (win_idx)
  );

  // A voice released this cycle still reads as busy here; it is allocatable next cycle.
  lowest_set_pick #(.W(NUM_VOICES), .IDX_W(VIDX_W)) u_free (
    .vec   (free_vec),
    .found (free_found),
    .index (free_idx)
  );

`ifdef VOICE_STEAL_EN
  logic [NUM_VOICES-1:0] oldest_vec;
  logic                  steal_found;
  age_t                  max_age;

  // Voices being released this cycle are not steal candidates.
  always_comb begin
    max_age = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_q[v].en && !rel_voice[v] && voice_q[v].age > max_age)
        max_age = voice_q[v].age;
    end
    for (int v = 0; v < NUM_VOICES; v++)
      oldest_vec[v] = voice_q[v].en & ~rel_voice[v] & (voice_q[v].age == max_age);
  end

  lowest_set_pick #(.W(NUM_VOICES), .IDX_W(VIDX_W)) u_oldest (
    .vec   (oldest_vec),
    .found (steal_found),
    .index (steal_idx)
  );

  assign do_steal = win_found & ~free_found & steal_found;
`else
  assign steal_idx = '0;
  assign do_steal  = 1'b0;
`endif

  assign grant  = win_found & (free_found | do_steal);
  assign target = free_found ? free_idx : steal_idx;

  always_comb begin
    win_onehot    = grant    ? (NUM_KEYS'(1) << win_idx)             : '0;
    stolen_onehot = do_steal ? (NUM_KEYS'(1) << voice_q[target].key) : '0;
    granted_n     = (granted_q & ~key_rel & ~stolen_onehot) | win_onehot;
    pending_n     = req & ~win_onehot;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_n[v] = voice_q[v];
      if (grant && target == VIDX_W'(v)) begin
        voice_n[v].en  = 1'b1;
        voice_n[v].key = win_idx;
        voice_n[v].age = '0;
      end else if (voice_q[v].en && !rel_voice[v]) begin
        voice_n[v].en  = 1'b1;
        voice_n[v].age = (voice_q[v].age == '1) ? voice_q[v].age : voice_q[v].age + 1'b1;
      end else begin
        voice_n[v].en  = 1'b0;
        voice_n[v].age = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q     <= '0;
      pending_q <= '0;
      granted_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++)
        voice_q[v] <= '0;
    end else begin
      key_q     <= key_req;
      pending_q <= pending_n;
      granted_q <= granted_n;
      for (int v = 0; v < NUM_VOICES; v++)
        voice_q[v] <= voice_n[v];
    end
  end

  always_comb begin
    voices_used = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_en[v]                  = voice_q[v].en;
      voice_key[v*KEY_W +: KEY_W]  = voice_q[v].key;
      voices_used                  = voices_used + CNT_W'(voice_q[v].en);
    end
  end

  assign key_granted = granted_q;
  assign pending     = pending_q;
  assign busy        = |pending_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: directed key patterns, expected outputs queued per cycle.
module tb_voice_allocator;

  logic        clk;
  logic        rst_n;
  logic [7:0]  key_req;
  logic [3:0]  voice_en;
  logic [11:0] voice_key;
  logic [7:0]  key_granted;
  logic [7:0]  pending;
  logic        busy;
  logic [2:0]  voices_used;

  voice_allocator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_req     (key_req),
    .voice_en    (voice_en),
    .voice_key   (voice_key),
    .key_granted (key_granted),
    .pending     (pending),
    .busy        (busy),
    .voices_used (voices_used)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [3:0]  en;
    logic [11:0] keys;
    logic [7:0]  gr;
    logic [7:0]  pend;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s: actual=%0h required=%0h", nm, fld, got, exp);
    end
  endtask

  // Monitor: outputs settle after posedge; compare every entry due by this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [11:0] m;
      e = sb.pop_front();
      for (int v = 0; v < 4; v++) m[v*3 +: 3] = {3{e.en[v]}};
      chk(e.name, "voice_en",    32'(voice_en),        32'(e.en));
      chk(e.name, "voice_key",   32'(voice_key & m),   32'(e.keys & m));
      chk(e.name, "key_granted", 32'(key_granted),     32'(e.gr));
      chk(e.name, "pending",     32'(pending),         32'(e.pend));
      chk(e.name, "busy",        32'(busy),            32'(|e.pend));
      chk(e.name, "voices_used", 32'(voices_used),     32'($countones(e.en)));
    end
  end

  // Drive inputs for the next edge and queue the outputs expected right after it.
  task automatic step(input logic [7:0] k, input logic r, input string nm,
                      input logic [3:0] en, input logic [11:0] keys,
                      input logic [7:0] gr, input logic [7:0] pd);
    exp_t e;
    @(negedge clk);
    key_req = k;
    rst_n   = r;
    e.cyc  = cyc + 1;
    e.name = nm;
    e.en   = en;
    e.keys = keys;
    e.gr   = gr;
    e.pend = pd;
    sb.push_back(e);
  endtask

  initial begin
    rst_n   = 1'b0;
    key_req = 8'h00;

    // Reset with every key held, then release.
    repeat (3) step(8'hFF, 1'b0, "rst_hold", 4'b0000, 12'h000, 8'h00, 8'h00);
    step(8'hFF, 1'b1, "rst_rel_g0", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 8'h01, 8'hFE);
    step(8'hFF, 1'b1, "rst_rel_g1", 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}, 8'h03, 8'hFC);
    step(8'h00, 1'b0, "rst_again",  4'b0000, 12'h000, 8'h00, 8'h00);

    // Single press / hold / release.
    step(8'h04, 1'b1, "single_grant", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, 8'h04, 8'h00);
    step(8'h04, 1'b1, "single_hold",  4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, 8'h04, 8'h00);
    step(8'h00, 1'b1, "single_rel",   4'b0000, 12'h000, 8'h00, 8'h00);

    // Five-key burst into four voices.
    step(8'h1F, 1'b1, "burst_g0", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 8'h01, 8'h1E);
    step(8'h1F, 1'b1, "burst_g1", 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}, 8'h03, 8'h1C);
    step(8'h1F, 1'b1, "burst_g2", 4'b0111, {3'd0, 3'd2, 3'd1, 3'd0}, 8'h07, 8'h18);
    step(8'h1F, 1'b1, "burst_g3", 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0F, 8'h10);
`ifdef VOICE_STEAL_EN
    step(8'h1F, 1'b1, "burst_steal", 4'b1111, {3'd3, 3'd2, 3'd1, 3'd4}, 8'h1E, 8'h00);
    step(8'h1D, 1'b1, "burst_drop1", 4'b1101, {3'd3, 3'd2, 3'd0, 3'd4}, 8'h1C, 8'h00);
`else
    step(8'h1F, 1'b1, "burst_full",   4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0F, 8'h10);
    step(8'h1D, 1'b1, "burst_drop1",  4'b1101, {3'd3, 3'd2, 3'd0, 3'd0}, 8'h0D, 8'h10);
    step(8'h1D, 1'b1, "burst_refill", 4'b1111, {3'd3, 3'd2, 3'd4, 3'd0}, 8'h1D, 8'h00);
`endif
    step(8'h00, 1'b1, "burst_clear", 4'b0000, 12'h000, 8'h00, 8'h00);

    // Key 7 pressed with all voices busy, then released before a voice frees.
    step(8'h0F, 1'b1, "pc_g0", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 8'h01, 8'h0E);
    step(8'h0F, 1'b1, "pc_g1", 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}, 8'h03, 8'h0C);
    step(8'h0F, 1'b1, "pc_g2", 4'b0111, {3'd0, 3'd2, 3'd1, 3'd0}, 8'h07, 8'h08);
    step(8'h0F, 1'b1, "pc_g3", 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0F, 8'h00);
`ifdef VOICE_STEAL_EN
    step(8'h8F, 1'b1, "pc_steal7", 4'b1111, {3'd3, 3'd2, 3'd1, 3'd7}, 8'h8E, 8'h00);
    step(8'h0F, 1'b1, "pc_rel7",   4'b1110, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0E, 8'h00);
    step(8'h0E, 1'b1, "pc_rel0",   4'b1110, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0E, 8'h00);
    step(8'h0E, 1'b1, "pc_idle",   4'b1110, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0E, 8'h00);
`else
    step(8'h8F, 1'b1, "pc_press7",  4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0F, 8'h80);
    step(8'h0F, 1'b1, "pc_cancel7", 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0F, 8'h00);
    step(8'h0E, 1'b1, "pc_free0",   4'b1110, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0E, 8'h00);
    step(8'h0E, 1'b1, "pc_no7",     4'b1110, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h0E, 8'h00);
`endif
    step(8'h00, 1'b1, "pc_clear", 4'b0000, 12'h000, 8'h00, 8'h00);

    // Reset pulse while three voices sound; held keys come back as fresh presses.
    step(8'h07, 1'b1, "mr_g0",       4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 8'h01, 8'h06);
    step(8'h07, 1'b1, "mr_g1",       4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}, 8'h03, 8'h04);
    step(8'h07, 1'b1, "mr_g2",       4'b0111, {3'd0, 3'd2, 3'd1, 3'd0}, 8'h07, 8'h00);
    step(8'h07, 1'b0, "mr_reset",    4'b0000, 12'h000, 8'h00, 8'h00);
    step(8'h07, 1'b1, "mr_regrant0", 4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 8'h01, 8'h06);
    step(8'h07, 1'b1, "mr_regrant1", 4'b0011, {3'd0, 3'd0, 3'd1, 3'd0}, 8'h03, 8'h04);
    step(8'h07, 1'b1, "mr_regrant2", 4'b0111, {3'd0, 3'd2, 3'd1, 3'd0}, 8'h07, 8'h00);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d entries left required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
